// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 exception/interrupt controller.
//   Holds SR (idx 12), Cause (idx 13) and EPC (idx 14).
//   Raises req when an enabled interrupt or a synchronous exception
//   reaches commit, and captures EPC/BD/ExcCode on that edge.
// Ports:
//   clk, reset           system clock, async active-high reset
//   hwint[5:0]           hardware interrupt lines
//   vpc, bd_in           commit-stage PC and delay-slot flag
//   exc_code_in          synchronous exception code (0 = none)
//   we, cp0_addr, cp0_wdata  mtc0 write port (cp0_addr also selects mfc0)
//   eret                 return from exception
//   cp0_rdata            mfc0 read data (combinational)
//   req                  flush/redirect to handler_pc this cycle
//   epc_out              current EPC
//   handler_pc           constant handler entry address
module cp0_unit #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret,
  output logic [31:0] cp0_rdata,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_aligned;

  // vpc[1:0] never matters: EPC is always word aligned.
  logic unused_vpc;
  assign unused_vpc = ^vpc[1:0];

  assign int_req    = ie_q & ~exl_q & (|(hwint & im_q));
  assign exc_req    = ~exl_q & (exc_code_in != 5'd0);
  // Gated by reset so req stays low even with exc_code_in active in reset.
  assign req        = ~reset & (int_req | exc_req);
  assign pc_aligned = {vpc[31:2], 2'b00};

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hwint;
    exc_d = exc_q;
    epc_d = epc_q;
    if (req) begin
      // Any same-cycle mtc0 or eret is dropped; the handler entry wins.
      exl_d = 1'b1;
      exc_d = int_req ? 5'd0 : exc_code_in;
      bd_d  = bd_in;
      epc_d = bd_in ? (pc_aligned - 32'd4) : pc_aligned;
    end else begin
      if (we) begin
        case (cp0_addr)
          ADDR_SR: begin
            im_d  = cp0_wdata[15:10];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
          end
          ADDR_EPC: epc_d = {cp0_wdata[31:2], 2'b00};
          default: ;
        endcase
      end
      // Placed after the write so eret overrides an mtc0 to SR.EXL.
      if (eret) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
      ADDR_EPC:   cp0_rdata = epc_q;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  hwint;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic [31:0] cp0_rdata;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  int vectors    = 0;
  int miscompares = 0;

  cp0_unit dut (
    .clk        (clk),
    .reset      (reset),
    .hwint      (hwint),
    .vpc        (vpc),
    .bd_in      (bd_in),
    .exc_code_in(exc_code_in),
    .we         (we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .eret       (eret),
    .cp0_rdata  (cp0_rdata),
    .req        (req),
    .epc_out    (epc_out),
    .handler_pc (handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; hwint = '0; vpc = '0; bd_in = 1'b0; exc_code_in = 5'd5;
    we = 1'b0; cp0_addr = 5'd12; cp0_wdata = '0; eret = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc", 32'd0);
    chk("handler_pc", handler_pc, 32'h0000_4180);
    tick();
    tick();
    reset = 1'b0; exc_code_in = 5'd0;

    // interrupt entry
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    tick();
    we = 1'b0;
    rd(5'd12, "sr_write", 32'h0000_0401);
    hwint = 6'b000001; vpc = 32'h3008; bd_in = 1'b0;
    #1 chk("int_req", {31'd0, req}, 32'd1);
    tick();
    rd(5'd14, "int_epc", 32'h0000_3008);
    chk("int_epc_out", epc_out, 32'h0000_3008);
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd12, "int_sr_exl", 32'h0000_0403);
    chk("int_nested_req", {31'd0, req}, 32'd0);
    hwint = 6'b0; eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, "int_eret_sr", 32'h0000_0401);

    // delay-slot exception
    exc_code_in = 5'd4; vpc = 32'h3014; bd_in = 1'b1;
    #1 chk("bd_req", {31'd0, req}, 32'd1);
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0;
    rd(5'd14, "bd_epc", 32'h0000_3010);
    rd(5'd13, "bd_cause", 32'h8000_0010);
    rd(5'd12, "bd_sr", 32'h0000_0403);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // req collides with mtc0 EPC
    exc_code_in = 5'd12; vpc = 32'h3020;
    we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
    #1 chk("col_req", {31'd0, req}, 32'd1);
    tick();
    we = 1'b0; exc_code_in = 5'd0;
    rd(5'd14, "col_epc", 32'h0000_3020);
    rd(5'd13, "col_cause", 32'h0000_0030);
    eret = 1'b1;
    #1 chk("col_eret_req", {31'd0, req}, 32'd0);
    tick();
    eret = 1'b0;
    rd(5'd12, "col_eret_sr", 32'h0000_0401);

    // eret beats mtc0 to SR.EXL
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0402;
    tick();
    we = 1'b0;
    rd(5'd12, "sr_exl_set", 32'h0000_0402);
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0C03; eret = 1'b1;
    tick();
    we = 1'b0; eret = 1'b0;
    rd(5'd12, "eret_prio_sr", 32'h0000_0C01);

    // masked interrupt, then nested attempts under EXL
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0001;
    tick();
    we = 1'b0;
    hwint = 6'b000100;
    #1 chk("masked_req", {31'd0, req}, 32'd0);
    tick();
    rd(5'd13, "masked_ip", 32'h0000_1030);
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC03;
    tick();
    we = 1'b0; exc_code_in = 5'd3;
    #1 chk("nested_req", {31'd0, req}, 32'd0);
    tick();
    exc_code_in = 5'd0;
    rd(5'd14, "nested_epc", 32'h0000_3020);
    rd(5'd13, "nested_cause", 32'h0000_1030);
    hwint = 6'b0; eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, "nested_eret_sr", 32'h0000_FC01);

    // Cause read-only, EPC alignment, unimplemented index
    we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    cp0_addr = 5'd14; cp0_wdata = 32'h0000_5007;
    tick();
    cp0_addr = 5'd5; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    rd(5'd13, "cause_ro", 32'h0000_0030);
    rd(5'd14, "epc_align", 32'h0000_5004);
    chk("epc_out_wr", epc_out, 32'h0000_5004);
    rd(5'd5, "idx5_zero", 32'd0);

    // EPC wraparound
    exc_code_in = 5'd8; vpc = 32'h0; bd_in = 1'b1;
    #1 chk("wrap_req", {31'd0, req}, 32'd1);
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0;
    rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
    rd(5'd13, "wrap_cause", 32'h8000_0020);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // async reset mid-cycle
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFD;
    tick();
    we = 1'b0;
    rd(5'd12, "sr_mask", 32'h0000_FC01);
    #1 reset = 1'b1;
    #1 chk("async_sr", cp0_rdata, 32'd0);
    rd(5'd14, "async_epc", 32'd0);
    exc_code_in = 5'd2;
    #1 chk("async_req", {31'd0, req}, 32'd0);
    tick();
    exc_code_in = 5'd0;
    rd(5'd12, "rst_hold_sr", 32'd0);
    reset = 1'b0;
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0001;
    tick();
    we = 1'b0;
    rd(5'd12, "post_rst_sr", 32'h0000_0001);
    rd(5'd13, "post_rst_cause", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
